// File: rtl/pio_edge_poll_master.sv
// pio_edge_poll_master
//
// Avalon-MM master that periodically polls an edge-capturing PIO responder.
// Each poll reads the edge-capture register (word 3). When any edge bit is set
// it reads the data register (word 0), clears edge capture by writing 0 to
// word 3, and offers one event (data + edge mask) on a valid/ready stream.
//
// Ports:
//   clk              single clock, rising edge
//   reset            asynchronous, active-high
//   enable           1 = new polls may be launched from IDLE
//   avm_address      word address to the responder
//   avm_read         read request
//   avm_write        write request (only for the edge-capture clear)
//   avm_writedata    write data, constant 0
//   avm_readdata     responder read data; low DATA_WIDTH bits used
//   avm_waitrequest  responder stall
//   evt_valid        event available
//   evt_ready        consumer accepts event
//   evt_data         data register value captured for the event
//   evt_edges        edge-capture value that triggered the event
//   busy             high whenever the FSM is outside IDLE
//
// State table
//   state   | meaning
//   IDLE    | poll timer counting down (only while enable=1)
//   RD_EDGE | read request to edge-capture register, held through stalls
//   WT_EDGE | waiting READ_LATENCY cycles for edge-capture read data
//   RD_DATA | read request to data register, held through stalls
//   WT_DATA | waiting READ_LATENCY cycles for data read data
//   WR_CLR  | write 0 to edge-capture register, held through stalls
//   PUSH    | event offered until the consumer takes it

module pio_edge_poll_master #(
    parameter int DATA_WIDTH    = 10,
    parameter int POLL_INTERVAL = 1000,
    parameter int READ_LATENCY  = 1,
    parameter int ADDR_WIDTH    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_waitrequest,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [DATA_WIDTH-1:0] evt_data,
    output logic [DATA_WIDTH-1:0] evt_edges,
    output logic                  busy
);

    localparam int TIMER_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [TIMER_W-1:0]    TIMER_RELOAD = TIMER_W'(POLL_INTERVAL - 1);
    localparam logic [LAT_W-1:0]      LAT_RELOAD   = LAT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA    = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_EDGE    = ADDR_WIDTH'(3);

    typedef enum logic [2:0] {
        IDLE,
        RD_EDGE,
        WT_EDGE,
        RD_DATA,
        WT_DATA,
        WR_CLR,
        PUSH
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [TIMER_W-1:0]      timer;
    logic [LAT_W-1:0]        lat_cnt;
    logic [DATA_WIDTH-1:0]   edge_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [DATA_WIDTH-1:0]   rd_sample;
    logic                    rd_done;
    logic                    unused_readdata;

    assign rd_sample       = avm_readdata[DATA_WIDTH-1:0];
    // Upper read data bits are intentionally ignored.
    assign unused_readdata = ^avm_readdata;

    // Read data is valid once the latency down-counter reaches terminal count.
    assign rd_done = (lat_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer    <= TIMER_RELOAD;
            lat_cnt  <= LAT_RELOAD;
            edge_reg <= '0;
            data_reg <= '0;
        end else begin
            // Anything other than an enabled countdown in IDLE parks the timer
            // at its reload value, so each IDLE entry starts a full interval.
            if (state == IDLE && enable && timer != '0) begin
                timer <= timer - 1'b1;
            end else begin
                timer <= TIMER_RELOAD;
            end

            if ((state == RD_EDGE || state == RD_DATA) && !avm_waitrequest) begin
                lat_cnt <= LAT_RELOAD;
            end else if ((state == WT_EDGE || state == WT_DATA) && !rd_done) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (state == WT_EDGE && rd_done) begin
                edge_reg <= rd_sample;
            end
            if (state == WT_DATA && rd_done) begin
                data_reg <= rd_sample;
            end
        end
    end

    always_comb begin
        state_next  = state;
        avm_read    = 1'b0;
        avm_write   = 1'b0;
        avm_address = '0;
        evt_valid   = 1'b0;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                if (enable && timer == '0) begin
                    state_next = RD_EDGE;
                end
            end
            RD_EDGE: begin
                avm_read    = 1'b1;
                avm_address = ADDR_EDGE;
                if (!avm_waitrequest) begin
                    state_next = WT_EDGE;
                end
            end
            WT_EDGE: begin
                if (rd_done) begin
                    state_next = (rd_sample == '0) ? IDLE : RD_DATA;
                end
            end
            RD_DATA: begin
                avm_read    = 1'b1;
                avm_address = ADDR_DATA;
                if (!avm_waitrequest) begin
                    state_next = WT_DATA;
                end
            end
            WT_DATA: begin
                if (rd_done) begin
                    state_next = WR_CLR;
                end
            end
            WR_CLR: begin
                avm_write   = 1'b1;
                avm_address = ADDR_EDGE;
                if (!avm_waitrequest) begin
                    state_next = PUSH;
                end
            end
            PUSH: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign avm_writedata = '0;
    assign evt_data      = data_reg;
    assign evt_edges     = edge_reg;

endmodule

// File: tb/tb_pio_edge_poll_master.sv
// Testbench for pio_edge_poll_master with a small edge-capturing PIO responder
// model (configurable wait states, one-cycle read latency) and bus/event
// monitors. POLL_INTERVAL is 4 so a no-edge poll repeats every 6 cycles and an
// edge poll spans 6 cycles from the edge read to the event transfer.

module tb_pio_edge_poll_master;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'hFFFF_FFFF;
    logic        avm_waitrequest;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [9:0]  evt_data;
    logic [9:0]  evt_edges;
    logic        busy;

    pio_edge_poll_master #(
        .DATA_WIDTH   (10),
        .POLL_INTERVAL(P),
        .READ_LATENCY (1),
        .ADDR_WIDTH   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_data       (evt_data),
        .evt_edges      (evt_edges),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // ---------------- responder model ----------------
    logic [31:0] rsp_edge = 32'h0;
    logic [31:0] rsp_data = 32'h0;
    logic [31:0] inject_mask = 32'h0;
    int          ws_n = 0;
    int          ws_wr_n = 0;
    int          ws_cnt = 0;
    int          cur_ws;

    assign cur_ws          = avm_write ? ws_wr_n : ws_n;
    assign avm_waitrequest = (avm_read || avm_write) && (ws_cnt < cur_ws);

    always @(posedge clk) begin
        if (avm_read || avm_write) begin
            ws_cnt <= (ws_cnt < cur_ws) ? ws_cnt + 1 : 0;
        end else begin
            ws_cnt <= 0;
        end
        if (avm_read && !avm_waitrequest) begin
            avm_readdata <= (avm_address == 2'd3) ? rsp_edge :
                            (avm_address == 2'd0) ? rsp_data : 32'h0;
        end else begin
            avm_readdata <= 32'hFFFF_FFFF;
        end
        if (avm_write && !avm_waitrequest && avm_address == 2'd3) begin
            rsp_edge <= inject_mask;
        end else begin
            rsp_edge <= rsp_edge | inject_mask;
        end
    end

    // ---------------- monitors ----------------
    typedef struct {
        bit          is_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        int          held;
        int          cyc;
    } acc_t;

    typedef struct {
        logic [9:0] data;
        logic [9:0] edges;
        int         cyc;
    } evt_t;

    acc_t acc_q[$];
    evt_t evt_q[$];
    int   cyc = 0;
    int   valid_cycles = 0;
    int   stall_viol = 0;
    int   both_viol = 0;
    int   req_len = 0;
    bit   prev_stall = 0;
    logic p_rd, p_wr;
    logic [1:0]  p_addr;
    logic [31:0] p_wd;

    always @(posedge clk) begin
        acc_t a;
        evt_t e;
        if (reset) begin
            prev_stall = 0;
            req_len    = 0;
        end else begin
            if (avm_read && avm_write) both_viol++;
            if (prev_stall && (avm_read !== p_rd || avm_write !== p_wr ||
                               avm_address !== p_addr || avm_writedata !== p_wd))
                stall_viol++;
            prev_stall = (avm_read || avm_write) && avm_waitrequest;
            p_rd   = avm_read;
            p_wr   = avm_write;
            p_addr = avm_address;
            p_wd   = avm_writedata;
            if (avm_read || avm_write) req_len++;
            if ((avm_read || avm_write) && !avm_waitrequest) begin
                a.is_wr = avm_write;
                a.addr  = avm_address;
                a.wdata = avm_writedata;
                a.held  = req_len;
                a.cyc   = cyc;
                acc_q.push_back(a);
                req_len = 0;
            end
            if (evt_valid) valid_cycles++;
            if (evt_valid && evt_ready) begin
                e.data  = evt_data;
                e.edges = evt_edges;
                e.cyc   = cyc;
                evt_q.push_back(e);
            end
        end
        cyc++;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (avm_read !== 1'b0) $display("FAIL rst_read got %b want 0", avm_read); else pass_cnt++;
        total_cnt++; if (avm_write !== 1'b0) $display("FAIL rst_write got %b want 0", avm_write); else pass_cnt++;
        total_cnt++; if (avm_address !== 2'd0) $display("FAIL rst_address got %0d want 0", avm_address); else pass_cnt++;
        total_cnt++; if (avm_writedata !== 32'h0) $display("FAIL rst_writedata got %h want 0", avm_writedata); else pass_cnt++;
        total_cnt++; if (evt_valid !== 1'b0) $display("FAIL rst_evt_valid got %b want 0", evt_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (evt_data !== 10'h0) $display("FAIL rst_evt_data got %h want 0", evt_data); else pass_cnt++;
        total_cnt++; if (evt_edges !== 10'h0) $display("FAIL rst_evt_edges got %h want 0", evt_edges); else pass_cnt++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_enable();
        int base, e, evb, n;
        bit ok;
        base = acc_q.size();
        repeat (20) @(negedge clk);
        total_cnt++; if (acc_q.size() !== base) $display("FAIL en_low_access got %0d want %0d", acc_q.size(), base); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL en_low_busy got %b want 0", busy); else pass_cnt++;
        e = cyc;
        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (acc_q.size() > base) ok = 1;
        end
        if (!ok) begin
            total_cnt++; $display("FAIL en_first_read timeout");
        end else begin
            total_cnt++; if (acc_q[base].cyc !== e + P) $display("FAIL en_first_read_cycle got %0d want %0d", acc_q[base].cyc, e + P); else pass_cnt++;
            total_cnt++; if (acc_q[base].is_wr || acc_q[base].addr !== 2'd3) $display("FAIL en_first_read_addr got wr=%0d addr=%0d want rd addr 3", acc_q[base].is_wr, acc_q[base].addr); else pass_cnt++;
        end

        // drop enable while the data read is outstanding
        evb = evt_q.size();
        base = acc_q.size();
        rsp_data = 32'h0AA;
        inject_mask = 32'h0F0;
        @(negedge clk);
        inject_mask = 32'h0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            for (int j = base; j < acc_q.size(); j++)
                if (!acc_q[j].is_wr && acc_q[j].addr == 2'd0) ok = 1;
        end
        enable = 1'b0;
        if (!ok) begin
            total_cnt++; $display("FAIL en_drop_rd0 timeout");
        end
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (evt_q.size() > evb) ok = 1;
        end
        if (!ok) begin
            total_cnt++; $display("FAIL en_drop_event timeout");
        end else begin
            total_cnt++; if (evt_q[evb].data !== 10'h0AA) $display("FAIL en_drop_data got %h want 0aa", evt_q[evb].data); else pass_cnt++;
            total_cnt++; if (evt_q[evb].edges !== 10'h0F0) $display("FAIL en_drop_edges got %h want 0f0", evt_q[evb].edges); else pass_cnt++;
            total_cnt++; if (!acc_q[acc_q.size()-1].is_wr) $display("FAIL en_drop_clear got rd want wr"); else pass_cnt++;
        end
        n = acc_q.size();
        repeat (20) @(negedge clk);
        total_cnt++; if (acc_q.size() !== n) $display("FAIL en_drop_idle got %0d want %0d", acc_q.size(), n); else pass_cnt++;
        enable = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_no_edge();
        int base, evb, vc, bad;
        base = acc_q.size();
        evb  = evt_q.size();
        vc   = valid_cycles;
        repeat (36) @(negedge clk);
        bad = 0;
        for (int j = base; j < acc_q.size(); j++)
            if (acc_q[j].is_wr || acc_q[j].addr !== 2'd3) bad++;
        total_cnt++; if (acc_q.size() - base !== 6) $display("FAIL noedge_polls got %0d want 6", acc_q.size() - base); else pass_cnt++;
        total_cnt++; if (bad !== 0) $display("FAIL noedge_non_rd3 got %0d want 0", bad); else pass_cnt++;
        bad = 0;
        for (int j = base + 1; j < acc_q.size(); j++)
            if (acc_q[j].cyc - acc_q[j-1].cyc !== P + 2) bad++;
        total_cnt++; if (bad !== 0) $display("FAIL noedge_period bad_gaps=%0d want 0", bad); else pass_cnt++;
        total_cnt++; if (valid_cycles !== vc || evt_q.size() !== evb) $display("FAIL noedge_evt got %0d valid cycles want 0", valid_cycles - vc); else pass_cnt++;
    endtask

    task automatic test_event();
        int base, evb, vc, k;
        bit ok;
        base = acc_q.size();
        evb  = evt_q.size();
        vc   = valid_cycles;
        rsp_data = 32'hFFFF_F2A5;
        inject_mask = 32'h005;
        @(negedge clk);
        inject_mask = 32'h0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (evt_q.size() > evb) ok = 1;
        end
        if (!ok) begin
            total_cnt++; $display("FAIL evt_timeout");
            return;
        end
        k = -1;
        for (int j = acc_q.size() - 1; j >= base; j--)
            if (!acc_q[j].is_wr && acc_q[j].addr == 2'd0) k = j;
        if (k < base + 1) begin
            total_cnt++; $display("FAIL evt_rd0 got none want one");
            return;
        end
        total_cnt++; if (acc_q.size() !== k + 2) $display("FAIL evt_access_count got %0d want %0d", acc_q.size(), k + 2); else pass_cnt++;
        total_cnt++; if (acc_q[k-1].is_wr || acc_q[k-1].addr !== 2'd3) $display("FAIL evt_first_rd3 got wr=%0d addr=%0d", acc_q[k-1].is_wr, acc_q[k-1].addr); else pass_cnt++;
        total_cnt++; if (!acc_q[k+1].is_wr || acc_q[k+1].addr !== 2'd3 || acc_q[k+1].wdata !== 32'h0) $display("FAIL evt_clear got wr=%0d addr=%0d data=%h want wr 3 0", acc_q[k+1].is_wr, acc_q[k+1].addr, acc_q[k+1].wdata); else pass_cnt++;
        total_cnt++; if (evt_q[evb].edges !== 10'h005) $display("FAIL evt_edges got %h want 005", evt_q[evb].edges); else pass_cnt++;
        total_cnt++; if (evt_q[evb].data !== 10'h2A5) $display("FAIL evt_data got %h want 2a5", evt_q[evb].data); else pass_cnt++;
        total_cnt++; if (valid_cycles - vc !== 1) $display("FAIL evt_valid_len got %0d want 1", valid_cycles - vc); else pass_cnt++;
        total_cnt++; if (evt_q[evb].cyc - acc_q[k-1].cyc !== 5) $display("FAIL evt_latency got %0d want 5", evt_q[evb].cyc - acc_q[k-1].cyc); else pass_cnt++;
        total_cnt++; if (rsp_edge !== 32'h0) $display("FAIL evt_cleared got %h want 0", rsp_edge); else pass_cnt++;
    endtask

    task automatic test_waitstate();
        int base, evb, sv, k;
        bit ok;
        ws_n = 3;
        ws_wr_n = 3;
        sv = stall_viol;
        base = acc_q.size();
        evb  = evt_q.size();
        rsp_data = 32'h2A5;
        inject_mask = 32'h005;
        @(negedge clk);
        inject_mask = 32'h0;
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (evt_q.size() > evb) ok = 1;
        end
        ws_n = 0;
        ws_wr_n = 0;
        if (!ok) begin
            total_cnt++; $display("FAIL ws_timeout");
            return;
        end
        k = -1;
        for (int j = acc_q.size() - 1; j >= base; j--)
            if (!acc_q[j].is_wr && acc_q[j].addr == 2'd0) k = j;
        if (k < base + 1 || k + 1 >= acc_q.size()) begin
            total_cnt++; $display("FAIL ws_sequence got incomplete want rd3 rd0 wr3");
            return;
        end
        total_cnt++; if (acc_q[k-1].held !== 4) $display("FAIL ws_rd3_held got %0d want 4", acc_q[k-1].held); else pass_cnt++;
        total_cnt++; if (acc_q[k].held !== 4) $display("FAIL ws_rd0_held got %0d want 4", acc_q[k].held); else pass_cnt++;
        total_cnt++; if (acc_q[k+1].held !== 4 || !acc_q[k+1].is_wr) $display("FAIL ws_wr_held got %0d want 4", acc_q[k+1].held); else pass_cnt++;
        total_cnt++; if (stall_viol !== sv) $display("FAIL ws_stable got %0d unstable cycles want 0", stall_viol - sv); else pass_cnt++;
        total_cnt++; if (evt_q[evb].edges !== 10'h005) $display("FAIL ws_edges got %h want 005", evt_q[evb].edges); else pass_cnt++;
        total_cnt++; if (evt_q[evb].data !== 10'h2A5) $display("FAIL ws_data got %h want 2a5", evt_q[evb].data); else pass_cnt++;
        total_cnt++; if (both_viol !== 0) $display("FAIL ws_rd_wr_overlap got %0d want 0", both_viol); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n, evb, bad, t;
        bit ok;
        evt_ready = 1'b0;
        rsp_data = 32'h155;
        inject_mask = 32'h003;
        @(negedge clk);
        inject_mask = 32'h0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (evt_valid) ok = 1;
        end
        if (!ok) begin
            total_cnt++; $display("FAIL bp_valid timeout");
            evt_ready = 1'b1;
            return;
        end
        total_cnt++; if (evt_data !== 10'h155) $display("FAIL bp_data got %h want 155", evt_data); else pass_cnt++;
        total_cnt++; if (evt_edges !== 10'h003) $display("FAIL bp_edges got %h want 003", evt_edges); else pass_cnt++;
        n = acc_q.size();
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!evt_valid || evt_data !== 10'h155 || evt_edges !== 10'h003 || !busy) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else pass_cnt++;
        total_cnt++; if (acc_q.size() !== n) $display("FAIL bp_no_access got %0d want %0d", acc_q.size(), n); else pass_cnt++;
        evb = evt_q.size();
        evt_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (evt_q.size() !== evb + 1) $display("FAIL bp_transfer got %0d want %0d", evt_q.size() - evb, 1); else pass_cnt++;
        total_cnt++; if (evt_valid !== 1'b0) $display("FAIL bp_valid_drop got %b want 0", evt_valid); else pass_cnt++;
        if (evt_q.size() <= evb) return;
        t = evt_q[evb].cyc;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (acc_q.size() > n) ok = 1;
        end
        if (!ok) begin
            total_cnt++; $display("FAIL bp_restart timeout");
        end else begin
            total_cnt++; if (acc_q[n].cyc - t !== P + 1) $display("FAIL bp_restart got %0d want %0d", acc_q[n].cyc - t, P + 1); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int evb;
        bit ok;
        ws_wr_n = 100;
        rsp_data = 32'h3FF;
        inject_mask = 32'h201;
        @(negedge clk);
        inject_mask = 32'h0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (avm_write) ok = 1;
        end
        if (!ok) begin
            total_cnt++; $display("FAIL rmid_write timeout");
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (avm_write !== 1'b0) $display("FAIL rmid_write got %b want 0", avm_write); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (evt_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", evt_valid); else pass_cnt++;
        @(negedge clk);
        ws_wr_n = 0;
        reset = 1'b0;
        total_cnt++; if (rsp_edge !== 32'h201) $display("FAIL rmid_edges_kept got %h want 201", rsp_edge); else pass_cnt++;
        evb = evt_q.size();
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (evt_q.size() > evb) ok = 1;
        end
        if (!ok) begin
            total_cnt++; $display("FAIL rmid_event timeout");
            return;
        end
        total_cnt++; if (evt_q[evb].edges !== 10'h201) $display("FAIL rmid_edges got %h want 201", evt_q[evb].edges); else pass_cnt++;
        total_cnt++; if (evt_q[evb].data !== 10'h3FF) $display("FAIL rmid_data got %h want 3ff", evt_q[evb].data); else pass_cnt++;
        total_cnt++; if (rsp_edge !== 32'h0) $display("FAIL rmid_cleared got %h want 0", rsp_edge); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_enable();
        test_no_edge();
        test_event();
        test_waitstate();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
